// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arb_pkg                                                       |
// | Purpose  : Shared types and constants for the rr_sel_arbiter block:      |
// |            FSM state encoding and the burst-counter width.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package arb_pkg;

   // The grant-state encodings are chosen so that they equal the one-hot gnt
   // value they produce.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } arb_state_e;

   // Wide enough for MAX_BURST up to 15.
   localparam int BURST_CNT_W = 4;

   // Largest MAX_BURST the counter can represent.
   localparam int MAX_BURST_LIMIT = (1 << BURST_CNT_W) - 1;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_sel_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_sel_arbiter_if                                             |
// | Purpose  : Request/grant/select bundle between two requesters and the    |
// |            round-robin select arbiter.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface rr_sel_arbiter_if;

   logic [1:0] req;     // req[i] : request from source i
   logic       sel;     // downstream 2:1 mux select
   logic [1:0] gnt;     // one-hot grant, 2'b00 when idle
   logic       valid;   // mux output is meaningful

   // Requester side: drives requests, observes the arbitration result.
   modport master (
      output req,
      input  sel,
      input  gnt,
      input  valid
   );

   // Arbiter side.
   modport slave (
      input  req,
      output sel,
      output gnt,
      output valid
   );

endinterface : rr_sel_arbiter_if
`default_nettype wire

// File: rtl/burst_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : burst_counter                                                 |
// | Purpose  : Saturating count of consecutive cycles one grant has been     |
// |            held. Clears on grant entry, increments while the grant is    |
// |            held, saturates at MAX_BURST. tc_o flags the last allowed     |
// |            cycle (count >= MAX_BURST-1). Used only when                  |
// |            ARB_BURST_LIMIT_EN is defined.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module burst_counter
   import arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);

   localparam logic [BURST_CNT_W-1:0] CNT_MAX = BURST_CNT_W'(MAX_BURST);
   localparam logic [BURST_CNT_W-1:0] CNT_TC  = BURST_CNT_W'(MAX_BURST - 1);

   logic [BURST_CNT_W-1:0] cnt_q;
   logic [BURST_CNT_W-1:0] cnt_d;

   // Next count: clear wins over increment, and the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q >= CNT_TC);

endmodule : burst_counter
`default_nettype wire

// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_sel_arbiter                                                |
// | Purpose  : Two-source round-robin arbiter driving a 2:1 mux select.      |
// |            IDLE/G0/G1 FSM, last-granted pointer and registered           |
// |            gnt/sel/valid outputs (1-cycle latency from req).             |
// | Config   : ARB_BURST_LIMIT_EN - when defined, a grant is limited to      |
// |            MAX_BURST consecutive cycles while the other source waits.    |
// |            When undefined, a grant is held until its request drops.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_sel_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rr_sel_arbiter_if.slave        bus
);

   // Reject MAX_BURST values the counter cannot represent.
   generate
      if ((MAX_BURST < 1) || (MAX_BURST > MAX_BURST_LIMIT)) begin : g_bad_max_burst
         $error("rr_sel_arbiter: MAX_BURST out of range 1..15");
      end
   endgenerate

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_q;      // last-granted source
   logic       last_d;
   logic [1:0] gnt_q;
   logic [1:0] gnt_d;
   logic       sel_q;
   logic       sel_d;
   logic       valid_q;
   logic       valid_d;
   logic       burst_tc;    // current grant has used its last allowed cycle

`ifdef ARB_BURST_LIMIT_EN
   logic cnt_clr;
   logic cnt_inc;

   // Entering a new state restarts the burst; staying in a grant extends it.
   assign cnt_clr = (state_d != state_q);
   assign cnt_inc = (state_d == state_q) && (state_d != IDLE);

   burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .tc_o  (burst_tc)
   );
`else
   assign burst_tc = 1'b0;
`endif

   // Next-state and output decode; outputs follow the next state so they are
   // registered alongside it.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = 2'b00;
      sel_d   = sel_q;
      valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            case (bus.req)
               2'b01:   state_d = G0;
               2'b10:   state_d = G1;
               2'b11:   state_d = last_q ? G0 : G1;
               default: state_d = IDLE;
            endcase
         end
         G0: begin
            if (bus.req[0] && !(burst_tc && bus.req[1])) begin
               state_d = G0;
            end else if (bus.req[1]) begin
               state_d = G1;
            end else begin
               state_d = IDLE;
            end
         end
         G1: begin
            if (bus.req[1] && !(burst_tc && bus.req[0])) begin
               state_d = G1;
            end else if (bus.req[0]) begin
               state_d = G0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         G0: begin
            gnt_d   = 2'b01;
            sel_d   = 1'b0;
            valid_d = 1'b1;
            last_d  = 1'b0;
         end
         G1: begin
            gnt_d   = 2'b10;
            sel_d   = 1'b1;
            valid_d = 1'b1;
            last_d  = 1'b1;
         end
         default: begin
            gnt_d   = 2'b00;
            valid_d = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output registers and round-robin pointer (pointer resets so source 0 wins first).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q   <= 2'b00;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.sel   = sel_q;
   assign bus.valid = valid_q;

endmodule : rr_sel_arbiter
`default_nettype wire

// File: tb/tb_rr_sel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rr_sel_arbiter                                             |
// | Purpose  : Scoreboard bench for rr_sel_arbiter. A grant-ownership model  |
// |            predicts gnt/sel/valid per cycle; a monitor compares them.    |
// | Config   : follows ARB_BURST_LIMIT_EN for the expected burst behaviour.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rr_sel_arbiter;

   localparam int MAX_BURST = 4;
`ifdef ARB_BURST_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] gnt;
      logic       sel;
      logic       valid;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rr_sel_arbiter_if bus ();

   rr_sel_arbiter #(
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   // Reference model: who owns the mux, for how many cycles, who went last.
   int   m_owner;   // -1 = nobody
   int   m_held;    // cycles the current owner has held the grant
   int   m_last;
   logic m_sel;

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_sel   = 1'b0;
   endtask

   task automatic model_step(input logic [1:0] r);
      int nxt;
      int oth;
      bit limit_hit;
      nxt = -1;
      oth = 0;
      limit_hit = 1'b0;
      if (m_owner < 0) begin
         if (r == 2'b01)      nxt = 0;
         else if (r == 2'b10) nxt = 1;
         else if (r == 2'b11) nxt = 1 - m_last;
      end else begin
         oth = 1 - m_owner;
         limit_hit = LIMIT_EN && (m_held >= MAX_BURST) && (r[oth] == 1'b1);
         if ((r[m_owner] == 1'b1) && !limit_hit) nxt = m_owner;
         else if (r[oth] == 1'b1)                nxt = oth;
      end
      if (nxt >= 0 && nxt == m_owner) m_held = m_held + 1;
      else                            m_held = (nxt >= 0) ? 1 : 0;
      if (nxt >= 0) begin
         m_last = nxt;
         m_sel  = (nxt == 1);
      end
      m_owner = nxt;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      if (m_owner == 0)      e = '{gnt: 2'b01, sel: 1'b0, valid: 1'b1};
      else if (m_owner == 1) e = '{gnt: 2'b10, sel: 1'b1, valid: 1'b1};
      else                   e = '{gnt: 2'b00, sel: m_sel, valid: 1'b0};
      return e;
   endfunction

   // One cycle: drive req (and rst_n) mid-cycle, predict after the edge.
   // Asserting reset while it is high also checks the asynchronous clear.
   task automatic drive_cycle(input logic [1:0] r, input logic rst_lvl);
      @(negedge clk);
      #2;
      bus.req = r;
      if (!rst_lvl && rst_n) begin
         rst_n = 1'b0;
         #1;
         checks++;
         if (bus.gnt !== 2'b00 || bus.sel !== 1'b0 || bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got gnt=%b sel=%b valid=%b, expected gnt=00 sel=0 valid=0",
                     bus.gnt, bus.sel, bus.valid);
         end
      end else begin
         rst_n = rst_lvl;
      end
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         model_step(r);
      end
      exp_q.push_back(model_out());
   endtask

   // Monitor: outputs are registered, so one expectation per cycle.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.gnt !== e.gnt || bus.sel !== e.sel || bus.valid !== e.valid) begin
               failures++;
               $display("FAIL scoreboard @%0t: got gnt=%b sel=%b valid=%b, expected gnt=%b sel=%b valid=%b",
                        $time, bus.gnt, bus.sel, bus.valid, e.gnt, e.sel, e.valid);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [1:0] r;
      int         len;

      bus.req = 2'b00;
      rst_n   = 1'b1;
      model_reset();
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 2'b00 || bus.sel !== 1'b0 || bus.valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got gnt=%b sel=%b valid=%b, expected gnt=00 sel=0 valid=0",
                  bus.gnt, bus.sel, bus.valid);
      end

      // Reset held, then idle, then a single request from source 0.
      repeat (2) drive_cycle(2'b00, 1'b0);
      repeat (2) drive_cycle(2'b00, 1'b1);
      drive_cycle(2'b01, 1'b1);
      drive_cycle(2'b00, 1'b1);

      // Fresh reset, then both requesting: source 0 first, direct handover.
      drive_cycle(2'b00, 1'b0);
      drive_cycle(2'b00, 1'b1);
      drive_cycle(2'b11, 1'b1);
      drive_cycle(2'b10, 1'b1);

      // Sustained contention, then a lone long request.
      repeat (20) drive_cycle(2'b11, 1'b1);
      repeat (10) drive_cycle(2'b01, 1'b1);
      drive_cycle(2'b00, 1'b1);

      // Both drop together, then reset asserted mid-grant in G1.
      drive_cycle(2'b11, 1'b1);
      drive_cycle(2'b00, 1'b1);
      repeat (3) drive_cycle(2'b10, 1'b1);
      drive_cycle(2'b10, 1'b0);
      drive_cycle(2'b10, 1'b0);
      drive_cycle(2'b10, 1'b1);
      drive_cycle(2'b11, 1'b1);

      // Randomized request runs with occasional reset pulses.
      for (int it = 0; it < 80; it++) begin
         r   = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 8);
         if ($urandom_range(0, 19) == 0) begin
            drive_cycle(r, 1'b0);
            drive_cycle(r, 1'b1);
         end else begin
            for (int k = 0; k < len; k++) drive_cycle(r, 1'b1);
         end
      end

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rr_sel_arbiter
`default_nettype wire
